// File: rtl/dmem_line_responder.sv
// rtl/dmem_line_responder.sv - fixed-latency 256-bit line memory responder behind the data-cache port
//
// Purpose: accepts one line read/write at a time, holds it for LATENCY cycles,
// commits it to the internal line array and pulses ack_o for one cycle.
// Optional feature macro: DMEM_ADDR_CHECK_EN (out-of-range address check, sticky err_o).
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-low reset
//   addr_i    byte address of the line, bits [4:0] ignored
//   data_i    write line data
//   enable_i  request valid
//   write_i   1 = write line, 0 = read line
//   ack_o     one-cycle completion pulse
//   data_o    last read line data
//   err_o     sticky out-of-range flag (0 when the check is compiled out)
module dmem_line_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         err_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t             state;
  logic [7:0]         count;
  logic [IDX_W-1:0]   idx_q;
  logic [255:0]       wdata_q;
  logic               write_q;
  logic               commit;
  logic               in_range;

  // Array is never reset: contents must survive a controller reset.
  logic [255:0]       mem [DEPTH];

  // Commit happens on the edge where the countdown has already reached zero.
  assign commit = (state == BUSY) && (count == 8'd0);

`ifdef DMEM_ADDR_CHECK_EN
  logic oor_q;
  logic err_q;
  logic unused_addr;
  assign unused_addr = ^addr_i[4:0];
  assign in_range    = ~oor_q;
  assign err_o       = err_q;
`else
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};
  assign in_range    = 1'b1;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (commit && write_q && in_range) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // The counter is loaded with LATENCY-1 and the commit edge is the one that
  // sees zero, so ack_o rises exactly LATENCY edges after acceptance for every
  // legal LATENCY, including 1 (zero cycles spent counting down).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      count   <= 8'd0;
      ack_o   <= 1'b0;
      data_o  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack_o <= 1'b0;
          if (enable_i) begin
            idx_q   <= addr_i[5+IDX_W-1:5];
            wdata_q <= data_i;
            write_q <= write_i;
`ifdef DMEM_ADDR_CHECK_EN
            oor_q   <= (addr_i[31:5] >= 27'(DEPTH));
`endif
            count   <= 8'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (count == 8'd0) begin
            if (!write_q) begin
              data_o <= in_range ? mem[idx_q] : '0;
            end
`ifdef DMEM_ADDR_CHECK_EN
            if (oor_q) begin
              err_q <= 1'b1;
            end
`endif
            ack_o <= 1'b1;
            state <= ACK;
          end else begin
            count <= count - 8'd1;
          end
        end
        ACK: begin
          // enable_i is deliberately ignored here: this is the turnaround cycle.
          ack_o <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// tb/tb_dmem_line_responder.sv - scoreboard bench for dmem_line_responder
module tb_dmem_line_responder;

  localparam int LAT = 10;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         err_o;

  dmem_line_responder #(.LATENCY(LAT), .DEPTH(512)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [255:0] data;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [255:0] last_rd = '0;
  logic         err_m = 1'b0;

  always @(posedge clk_i) cyc++;

  function automatic void check(string nm, logic [255:0] act, logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  task automatic push_exp(logic [255:0] d, int c);
    exp_t e;
    e.data = d;
    e.err  = err_m;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor: every ack pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack actual_cycle=%0d required=none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("data_o", data_o, e.data);
        check("err_o", {255'd0, err_o}, {255'd0, e.err});
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < LAT + 8) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
    @(negedge clk_i);
  endtask

  // Issue one request; enable_i held for 'hold' negedges, then inputs scrambled
  // to show the latched request is what gets committed.
  task automatic do_req(logic [31:0] a, logic [255:0] d, logic w, logic [255:0] exp_d, int hold);
    @(negedge clk_i);
    addr_i = a; data_i = d; write_i = w; enable_i = 1'b1;
    push_exp(exp_d, cyc + 1 + LAT);
    repeat (hold) @(negedge clk_i);
    enable_i = 1'b0; addr_i = ~a; data_i = ~d; write_i = ~w;
    wait_drain();
  endtask

  task automatic wr(logic [31:0] a, logic [255:0] d, int hold);
    do_req(a, d, 1'b1, last_rd, hold);
  endtask

  task automatic rd(logic [31:0] a, logic [255:0] d);
    do_req(a, '0, 1'b0, d, 1);
    last_rd = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] pa5, p0, p9, p7, pff, pdead, p1234;
    int c0;
    pa5   = {32{8'hA5}};
    p0    = {32{8'hC3}};
    p9    = {8{32'h0909_0909}};
    p7    = {8{32'hD7D7_0707}};
    pff   = {256{1'b1}};
    pdead = {8{32'hDEAD_BEEF}};
    p1234 = 256'h1234;

    rst_i = 1'b0; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      check("idle_ack", {255'd0, ack_o}, '0);
      check("idle_data", data_o, '0);
      check("idle_err", {255'd0, err_o}, '0);
    end

    // Preload lines 0, 3, 5, 9 through the write path.
    wr(32'h0000_0000, p0, 1);
    wr(32'h0000_0060, pa5, 1);
    wr(32'h0000_00A0, '0, 1);
    wr(32'h0000_0120, p9, 1);

    rd(32'h0000_0060, pa5);

    // enable_i held past acceptance for two more cycles still yields one ack.
    wr(32'h0000_0400, p1234, 3);
    rd(32'h0000_0400, p1234);

    // Write-back then refill with enable_i held high throughout.
    @(negedge clk_i);
    addr_i = 32'h0000_00E0; data_i = p7; write_i = 1'b1; enable_i = 1'b1;
    c0 = cyc;
    push_exp(last_rd, c0 + 1 + LAT);
    push_exp(p9, c0 + 1 + LAT + 2 + LAT);
    @(negedge clk_i);
    addr_i = 32'h0000_0120; data_i = pdead; write_i = 1'b0;
    while (cyc < c0 + 3 + LAT) @(negedge clk_i);
    enable_i = 1'b0;
    last_rd = p9;
    wait_drain();
    rd(32'h0000_00E0, p7);

    // Reset while a write to line 5 is counting down (counter = 4).
    @(negedge clk_i);
    addr_i = 32'h0000_00A0; data_i = pff; write_i = 1'b1; enable_i = 1'b1;
    @(negedge clk_i);
    enable_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_ack", {255'd0, ack_o}, '0);
    check("rst_data", data_o, '0);
    repeat (2) @(negedge clk_i);
    check("rst_hold_ack", {255'd0, ack_o}, '0);
    rst_i = 1'b1;
    last_rd = '0;
    err_m = 1'b0;
    repeat (LAT + 4) @(negedge clk_i);
    rd(32'h0000_00A0, '0);

    // Address beyond DEPTH lines.
`ifdef DMEM_ADDR_CHECK_EN
    err_m = 1'b1;
    wr(32'h0001_0000, pdead, 1);
    rd(32'h0001_0000, '0);
    rd(32'h0000_0000, p0);
`else
    wr(32'h0001_0000, pdead, 1);
    rd(32'h0001_0000, pdead);
    rd(32'h0000_0000, pdead);
`endif
    check("err_final", {255'd0, err_o}, {255'd0, err_m});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
